// File: rtl/freq_pkg.sv
// Shared definitions for the frequency measurement path (freq_detector -> period_to_freq).
// Holds the controller state encoding and the default widths and sample rate.
package freq_pkg;

    localparam int          PERIOD_WIDTH_DEF = 12;
    localparam int          FREQ_WIDTH_DEF   = 32;
    localparam int unsigned FS_HZ_DEF        = 1_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Generic sequential restoring unsigned divider: one quotient bit per clock.
// done_o is high during the final iteration, so quotient_o is valid right after that edge.
module seq_udiv
    import freq_pkg::*;
#(
    parameter int DVD_WIDTH = 32,
    parameter int DVS_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [DVD_WIDTH-1:0] dividend_i,
    input  logic [DVS_WIDTH-1:0] divisor_i,
    output logic                 done_o,
    output logic [DVD_WIDTH-1:0] quotient_o,
    output logic [DVS_WIDTH-1:0] remainder_o
);

    localparam int             CW   = cnt_width(DVD_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DVD_WIDTH - 1);

    // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
    logic [DVD_WIDTH-1:0] dq_q, dq_d;
    logic [DVS_WIDTH:0]   rem_q, rem_d, rem_shift;
    logic [DVS_WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 run_q, run_d;

    always_comb begin
        rem_shift = {rem_q[DVS_WIDTH-1:0], dq_q[DVD_WIDTH-1]};
        dq_d      = dq_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        if (start_i) begin
            dq_d  = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
            cnt_d = LAST;
            run_d = 1'b1;
        end else if (run_q) begin
            if (rem_shift >= {1'b0, dvs_q}) begin
                rem_d = rem_shift - {1'b0, dvs_q};
                dq_d  = {dq_q[DVD_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_shift;
                dq_d  = {dq_q[DVD_WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dq_q  <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            dq_q  <= dq_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o      = run_q && (cnt_q == '0);
    assign quotient_o  = dq_q;
    assign remainder_o = rem_q[DVS_WIDTH-1:0];

endmodule

// File: rtl/period_to_freq.sv
// Converts a settled signal period (adc_clk samples) into frequency FS_HZ/period with a valid strobe.
// Define PERIOD_TO_FREQ_ROUND_EN to round to nearest instead of truncating.
//   state | meaning
//   IDLE  | waiting for a trigger (pending request)
//   DIV   | divider iterating, one quotient bit per cycle
//   DONE  | publish result or saturate; optionally restart with pending period
module period_to_freq
    import freq_pkg::*;
#(
    parameter int          PERIOD_WIDTH = PERIOD_WIDTH_DEF,
    parameter int          FREQ_WIDTH   = FREQ_WIDTH_DEF,
    parameter int unsigned FS_HZ        = FS_HZ_DEF
) (
    input  logic                    adc_clk,
    input  logic                    rst_n,
    input  logic                    stable,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic [FREQ_WIDTH-1:0]   freq,
    output logic                    freq_valid,
    output logic                    busy,
    output logic                    div_err
);

    localparam logic [FREQ_WIDTH-1:0] FS_VEC = FREQ_WIDTH'(FS_HZ);

    state_e                  state_q, state_d;
    logic                    stable_q;
    logic [PERIOD_WIDTH-1:0] last_period_q;
    logic                    pend_q;
    logic [PERIOD_WIDTH-1:0] pend_period_q;
    logic                    sat_q;
    logic [FREQ_WIDTH-1:0]   freq_q;
    logic                    freq_valid_q;
    logic                    div_err_q;

    logic                    trigger;
    logic                    launch;
    logic                    consume;
    logic                    div_start;
    logic                    div_done;
    logic [FREQ_WIDTH-1:0]   div_dividend;
    logic [FREQ_WIDTH-1:0]   div_quot;
    logic [PERIOD_WIDTH-1:0] div_rem_unused;

    assign trigger = stable && (!stable_q || (period != last_period_q));

`ifdef PERIOD_TO_FREQ_ROUND_EN
    assign div_dividend = FS_VEC + FREQ_WIDTH'(pend_period_q >> 1);
`else
    assign div_dividend = FS_VEC;
`endif

    // The pending slot doubles as the request register, so a trigger seen in IDLE
    // and one seen while busy take the same path.
    always_comb begin
        launch    = pend_q && ((state_q == IDLE) || ((state_q == DONE) && stable));
        consume   = pend_q && ((state_q == IDLE) || (state_q == DONE));
        div_start = launch && (pend_period_q != '0);
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = div_start ? DIV : DONE;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (launch) begin
                    state_d = div_start ? DIV : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            stable_q      <= 1'b0;
            last_period_q <= '0;
            pend_q        <= 1'b0;
            pend_period_q <= '0;
            sat_q         <= 1'b0;
            freq_q        <= '0;
            freq_valid_q  <= 1'b0;
            div_err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable;
            if (trigger) begin
                last_period_q <= period;
                pend_q        <= 1'b1;
                pend_period_q <= period;
            end else if (consume) begin
                pend_q <= 1'b0;
            end
            if (launch) begin
                sat_q <= (pend_period_q == '0);
            end
            freq_valid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                freq_q    <= sat_q ? '1 : div_quot;
                div_err_q <= sat_q;
            end
        end
    end

    seq_udiv #(
        .DVD_WIDTH (FREQ_WIDTH),
        .DVS_WIDTH (PERIOD_WIDTH)
    ) u_div (
        .clk_i       (adc_clk),
        .rst_n_i     (rst_n),
        .start_i     (div_start),
        .dividend_i  (div_dividend),
        .divisor_i   (pend_period_q),
        .done_o      (div_done),
        .quotient_o  (div_quot),
        .remainder_o (div_rem_unused)
    );

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign busy       = (state_q != IDLE);
    assign div_err    = div_err_q;

endmodule

// File: tb/tb_period_to_freq.sv
// Self-checking bench for period_to_freq: directed scenarios plus randomized periods
// checked against an arithmetic reference (FS_HZ / period, rounded when the macro is set).
module tb_period_to_freq;

    localparam int unsigned FS = 1_000_000;
    localparam int LAT      = 34;
    localparam int LAT_ZERO = 2;

    logic        adc_clk = 1'b0;
    logic        rst_n   = 1'b1;
    logic        stable  = 1'b0;
    logic [11:0] period  = '0;
    logic [31:0] freq;
    logic        freq_valid;
    logic        busy;
    logic        div_err;

    int n_cmp = 0;
    int n_err = 0;

    period_to_freq dut (
        .adc_clk    (adc_clk),
        .rst_n      (rst_n),
        .stable     (stable),
        .period     (period),
        .freq       (freq),
        .freq_valid (freq_valid),
        .busy       (busy),
        .div_err    (div_err)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        logic [31:0] f;
        logic        err;
        int          c;
    } ev_t;

    ev_t  evq[$];
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   dbl      = 0;
    logic prev_v   = 1'b0;

    always @(posedge adc_clk) cyc <= cyc + 1;

    always @(negedge adc_clk) begin
        if (freq_valid === 1'b1) evq.push_back('{freq, div_err, cyc});
        if (busy === 1'b1) busy_cnt++;
        if (freq_valid === 1'b1 && prev_v === 1'b1) dbl++;
        prev_v = freq_valid;
    end

    function automatic logic [31:0] ref_freq(input int unsigned p);
        longint unsigned n;
        if (p == 0) return 32'hFFFF_FFFF;
`ifdef PERIOD_TO_FREQ_ROUND_EN
        n = longint'(FS) + longint'(p / 2);
`else
        n = longint'(FS);
`endif
        return 32'(n / longint'(p));
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
        end
    endtask

    task automatic wait_ev(input int max_cyc, output bit ok, output ev_t e);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && evq.size() == 0; i++) @(negedge adc_clk);
        if (evq.size() > 0) begin
            ok = 1'b1;
            e  = evq.pop_front();
        end
    endtask

    task automatic test_reset();
        tick(1);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (freq !== 32'd0 || freq_valid !== 1'b0 || busy !== 1'b0 || div_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got freq=%0d valid=%b busy=%b err=%b, expected 0/0/0/0",
                     freq, freq_valid, busy, div_err);
        end
        tick(3);
        rst_n = 1'b1;
        tick(2);
        evq.delete();
    endtask

    task automatic test_single();
        bit  ok;
        ev_t e;
        int  k;
        tick(1);
        stable   = 1'b1;
        period   = 12'd1000;
        k        = cyc;
        busy_cnt = 0;
        wait_ev(80, ok, e);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL single_timeout: no freq_valid, expected freq %0d", ref_freq(1000));
        end else begin
            n_cmp++;
            if (e.f !== ref_freq(1000)) begin
                n_err++;
                $display("FAIL single_freq: got %0d expected %0d", e.f, ref_freq(1000));
            end
            n_cmp++;
            if (e.c != k + 1 + LAT) begin
                n_err++;
                $display("FAIL single_latency: got edge %0d expected %0d", e.c, k + 1 + LAT);
            end
            n_cmp++;
            if (e.err !== 1'b0) begin
                n_err++;
                $display("FAIL single_err: got %b expected 0", e.err);
            end
        end
        tick(40);
        n_cmp++;
        if (busy_cnt != 33) begin
            n_err++;
            $display("FAIL single_busy_cycles: got %0d expected 33", busy_cnt);
        end
        n_cmp++;
        if (evq.size() != 0 || freq !== ref_freq(1000)) begin
            n_err++;
            $display("FAIL single_hold: extra pulses %0d, freq %0d expected %0d",
                     evq.size(), freq, ref_freq(1000));
        end
    endtask

    task automatic test_steps();
        int  plist[5];
        bit  ok;
        ev_t e;
        int  k;
        plist = '{512, 400, 256, 2400, 2400};
        for (int i = 0; i < 5; i++) begin
            tick(1);
            period = 12'(plist[i]);
            k      = cyc;
            if (i == 4) begin
                tick(60);
                n_cmp++;
                if (evq.size() != 0) begin
                    n_err++;
                    $display("FAIL steps_equal_retrigger: got %0d pulses expected 0", evq.size());
                    evq.delete();
                end
            end else begin
                wait_ev(80, ok, e);
                n_cmp++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL steps_timeout: period %0d no result", plist[i]);
                end else begin
                    n_cmp++;
                    if (e.f !== ref_freq(plist[i]) || e.c != k + 1 + LAT || e.err !== 1'b0) begin
                        n_err++;
                        $display("FAIL steps_result: period %0d got freq %0d edge %0d err %b expected %0d edge %0d err 0",
                                 plist[i], e.f, e.c, e.err, ref_freq(plist[i]), k + 1 + LAT);
                    end
                end
                tick(4);
            end
        end
    endtask

    task automatic test_zero();
        bit  ok;
        ev_t e;
        int  k;
        tick(1);
        period = 12'd0;
        k      = cyc;
        wait_ev(20, ok, e);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL zero_timeout: no result for period 0");
        end else begin
            n_cmp++;
            if (e.f !== 32'hFFFF_FFFF || e.err !== 1'b1 || e.c != k + 1 + LAT_ZERO) begin
                n_err++;
                $display("FAIL zero_result: got freq %h err %b edge %0d expected ffffffff 1 edge %0d",
                         e.f, e.err, e.c, k + 1 + LAT_ZERO);
            end
        end
        tick(4);
        period = 12'd7;
        k      = cyc;
        wait_ev(80, ok, e);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL zero_recover_timeout: no result for period 7");
        end else begin
            n_cmp++;
            if (e.f !== ref_freq(7) || e.err !== 1'b0 || e.c != k + 1 + LAT) begin
                n_err++;
                $display("FAIL zero_recover: got freq %0d err %b edge %0d expected %0d 0 edge %0d",
                         e.f, e.err, e.c, ref_freq(7), k + 1 + LAT);
            end
        end
        tick(4);
    endtask

    task automatic test_pending();
        bit  ok;
        ev_t e1, e2;
        int  k;
        tick(1);
        period = 12'd1000;
        k      = cyc;
        tick(11);
        period = 12'd400;
        wait_ev(80, ok, e1);
        n_cmp++;
        if (!ok || e1.f !== ref_freq(1000) || e1.c != k + 1 + LAT) begin
            n_err++;
            $display("FAIL pending_first: got ok=%b freq %0d edge %0d expected %0d edge %0d",
                     ok, e1.f, e1.c, ref_freq(1000), k + 1 + LAT);
        end
        wait_ev(80, ok, e2);
        n_cmp++;
        if (!ok || e2.f !== ref_freq(400) || e2.c != e1.c + 33) begin
            n_err++;
            $display("FAIL pending_restart: got ok=%b freq %0d edge %0d expected %0d edge %0d",
                     ok, e2.f, e2.c, ref_freq(400), e1.c + 33);
        end
        tick(4);
        // Same again, but the settled flag drops before the first result is published.
        period = 12'd1000;
        k      = cyc;
        tick(11);
        period = 12'd400;
        tick(9);
        stable = 1'b0;
        wait_ev(80, ok, e1);
        n_cmp++;
        if (!ok || e1.f !== ref_freq(1000) || e1.c != k + 1 + LAT) begin
            n_err++;
            $display("FAIL pending_drop_first: got ok=%b freq %0d edge %0d expected %0d edge %0d",
                     ok, e1.f, e1.c, ref_freq(1000), k + 1 + LAT);
        end
        tick(80);
        n_cmp++;
        if (evq.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL pending_drop_extra: got %0d pulses busy=%b expected 0 pulses busy=0",
                     evq.size(), busy);
            evq.delete();
        end
    endtask

    task automatic test_reset_mid_div();
        bit  ok;
        ev_t e;
        int  k;
        tick(1);
        stable = 1'b1;
        period = 12'd1000;
        tick(16);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (freq !== 32'd0 || busy !== 1'b0 || div_err !== 1'b0 || freq_valid !== 1'b0) begin
            n_err++;
            $display("FAIL middiv_reset: got freq=%0d busy=%b err=%b valid=%b expected all 0",
                     freq, busy, div_err, freq_valid);
        end
        evq.delete();
        tick(4);
        rst_n = 1'b1;
        k     = cyc;
        wait_ev(80, ok, e);
        n_cmp++;
        if (!ok || e.f !== ref_freq(1000) || e.c != k + 1 + LAT || e.err !== 1'b0) begin
            n_err++;
            $display("FAIL middiv_after: got ok=%b freq %0d edge %0d err %b expected %0d edge %0d err 0",
                     ok, e.f, e.c, e.err, ref_freq(1000), k + 1 + LAT);
        end
        tick(4);
    endtask

    task automatic test_random();
        bit          ok;
        ev_t         e;
        int          k;
        int unsigned p;
        int unsigned last;
        int          lat;
        last = 1000;
        for (int i = 0; i < 12; i++) begin
            p = $urandom_range(4095, 1);
            if ($urandom_range(7, 0) == 0) p = 0;
            if (p == last) p = (p + 1) % 4096;
            tick(1);
            period = 12'(p);
            k      = cyc;
            lat    = (p == 0) ? LAT_ZERO : LAT;
            wait_ev(80, ok, e);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL random_timeout: period %0d no result", p);
            end else if (e.f !== ref_freq(p) || e.err !== (p == 0) || e.c != k + 1 + lat) begin
                n_err++;
                $display("FAIL random_result: period %0d got freq %0d err %b edge %0d expected %0d err %b edge %0d",
                         p, e.f, e.err, e.c, ref_freq(p), (p == 0), k + 1 + lat);
            end
            last = p;
            tick($urandom_range(6, 2));
        end
        n_cmp++;
        if (dbl != 0) begin
            n_err++;
            $display("FAIL valid_single_pulse: got %0d back-to-back valid cycles expected 0", dbl);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_single();
        test_steps();
        test_zero();
        test_pending();
        test_reset_mid_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
